// File: rtl/accum_pkg.sv
// accum_pkg: shared types for the multi-cycle accumulator.
//   accum_state_t : control FSM state encoding used by accum_unit.
package accum_pkg;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_HOLD = 2'd2
  } accum_state_t;

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit adder slice in generate/propagate form.
// Ports:
//   A, B  in  CHUNK  addends
//   cin   in  1      carry in
//   S     out CHUNK  sum
//   cout  out 1      carry out
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] A,
  input  logic [CHUNK-1:0] B,
  input  logic             cin,
  output logic [CHUNK-1:0] S,
  output logic             cout
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g = A & B;
  assign p = A ^ B;

  // Each carry is a flat sum of products of g/p/cin once unrolled.
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign S    = p ^ c[CHUNK-1:0];
  assign cout = c[CHUNK];

endmodule

// File: rtl/accum_unit.sv
// accum_unit: run-once accumulator adding CHUNK bits per cycle over
// N = WIDTH/CHUNK cycles with a registered carry between slices.
// Ports:
//   Clk       in  1        system clock
//   Reset     in  1        synchronous active-high reset
//   Run       in  1        operation request (level)
//   Load_Sel  in  1        1 = load Operand, 0 = accumulate Operand
//   Operand   in  WIDTH    input value
//   Acc_Out   out WIDTH+1  committed sum, MSB = carry out of last add
//   Busy      out 1        add in progress
//   Done      out 1        one-cycle pulse after each commit
//   Overflow  out 1        sticky carry-out flag
// Build option: ACCUM_SATURATE_EN clamps Acc_Out to all ones on carry out.
//
// state    | meaning
// ACC_IDLE | waiting for Run; samples Load_Sel/Operand
// ACC_ADD  | one slice per cycle, commit on the last slice
// ACC_HOLD | operation finished, waiting for Run release
module accum_unit
  import accum_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Load_Sel,
  input  logic [WIDTH-1:0] Operand,
  output logic [WIDTH:0]   Acc_Out,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  accum_state_t state, state_nxt;

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_final;
  logic [KW-1:0]    k;
  logic             carry;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_s;
  logic             slice_cout;
  logic             last_slice;
  int               base;

  always_comb begin
    base       = int'(k) * CHUNK;
    slice_a    = shadow[base +: CHUNK];
    slice_b    = work[base +: CHUNK];
    work_final = work;
    work_final[base +: CHUNK] = slice_s;
  end

  assign last_slice = (k == KW'(N - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .A    (slice_a),
    .B    (slice_b),
    .cin  (carry),
    .S    (slice_s),
    .cout (slice_cout)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= ACC_HOLD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC_IDLE: if (Run) state_nxt = Load_Sel ? ACC_HOLD : ACC_ADD;
      ACC_ADD:  if (last_slice) state_nxt = ACC_HOLD;
      ACC_HOLD: if (!Run) state_nxt = ACC_IDLE;
      default:  state_nxt = ACC_HOLD;
    endcase
  end

  assign Busy = (state == ACC_ADD);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Acc_Out  <= '0;
      Overflow <= 1'b0;
      Done     <= 1'b0;
      shadow   <= '0;
      work     <= '0;
      k        <= '0;
      carry    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ACC_IDLE: begin
          if (Run) begin
            if (Load_Sel) begin
              Acc_Out  <= {1'b0, Operand};
              Overflow <= 1'b0;
              Done     <= 1'b1;
            end else begin
              shadow <= Operand;
              work   <= Acc_Out[WIDTH-1:0];
              k      <= '0;
              carry  <= 1'b0;
            end
          end
        end
        ACC_ADD: begin
          work  <= work_final;
          carry <= slice_cout;
          k     <= k + KW'(1);
          if (last_slice) begin
`ifdef ACCUM_SATURATE_EN
            Acc_Out <= slice_cout ? '1 : {1'b0, work_final};
`else
            Acc_Out <= {slice_cout, work_final};
`endif
            Overflow <= Overflow | slice_cout;
            Done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_unit.sv
module tb_accum_unit #(
  parameter int W = 16,
  parameter int C = 4
);

  localparam int N = W / C;
`ifdef ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [W-1:0] ALL1 = {W{1'b1}};
  localparam logic [W:0]   TOPB = {1'b1, {W{1'b0}}};
  localparam logic [W:0]   SATV = {(W+1){1'b1}};

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         Run = 1'b0;
  logic         Load_Sel = 1'b0;
  logic [W-1:0] Operand = '0;
  logic [W:0]   Acc_Out;
  logic         Busy;
  logic         Done;
  logic         Overflow;

  int checks = 0;
  int failures = 0;

  logic [W:0] m_acc = '0;
  logic       m_ovf = 1'b0;

  typedef struct {
    logic         load;
    logic [W-1:0] op;
    logic [W:0]   exp_acc;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[12];

  accum_unit #(.WIDTH(W), .CHUNK(C)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Run      (Run),
    .Load_Sel (Load_Sel),
    .Operand  (Operand),
    .Acc_Out  (Acc_Out),
    .Busy     (Busy),
    .Done     (Done),
    .Overflow (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One full press: Run high until the commit, one HOLD cycle, then release.
  task automatic do_op(input logic load, input logic [W-1:0] op,
                       input logic [W:0] e_acc, input logic e_ovf, input string nm);
    int busy_n;
    busy_n   = 0;
    Run      = 1'b1;
    Load_Sel = load;
    Operand  = op;
    tick();
    while (Busy && busy_n < N + 2) begin
      busy_n++;
      chk({nm, " acc_hold"}, 64'(Acc_Out), 64'(m_acc));
      Operand  = ~op;
      Load_Sel = ~load;
      tick();
    end
    chk({nm, " busy_cycles"}, 64'(busy_n), load ? 64'd0 : 64'(N));
    chk({nm, " done"}, 64'(Done), 64'd1);
    chk({nm, " acc"}, 64'(Acc_Out), 64'(e_acc));
    chk({nm, " ovf"}, 64'(Overflow), 64'(e_ovf));
    tick();
    chk({nm, " done_once"}, 64'(Done), 64'd0);
    Run = 1'b0;
    tick();
    m_acc = e_acc;
    m_ovf = e_ovf;
  endtask

  initial begin
    int done_cnt, busy_cnt;
    logic         r_load;
    logic [W-1:0] r_op;
    logic [W:0]   r_sum;
    logic [W:0]   r_exp;
    logic         r_ovf;

    vecs[0]  = '{1'b1, W'('h1234), (W+1)'('h1234), 1'b0};
    vecs[1]  = '{1'b0, W'('h0001), (W+1)'('h1235), 1'b0};
    vecs[2]  = '{1'b1, ALL1, {1'b0, ALL1}, 1'b0};
    vecs[3]  = '{1'b0, W'('h0001), SAT ? SATV : TOPB, 1'b1};
    vecs[4]  = '{1'b0, W'('h0002), SAT ? SATV : (W+1)'('h2), 1'b1};
    vecs[5]  = '{1'b1, W'('h0005), (W+1)'('h5), 1'b0};
    vecs[6]  = '{1'b0, ALL1, SAT ? SATV : (TOPB | (W+1)'('h4)), 1'b1};
    vecs[7]  = '{1'b1, W'('h00F1), (W+1)'('h00F1), 1'b0};
    vecs[8]  = '{1'b0, W'('h0F0F), (W+1)'('h1000), 1'b0};
    vecs[9]  = '{1'b0, W'('h0000), (W+1)'('h1000), 1'b0};
    vecs[10] = '{1'b1, W'('h0000), (W+1)'('h0), 1'b0};
    vecs[11] = '{1'b0, W'('h0010), (W+1)'('h10), 1'b0};

    // Reset with Run held: nothing happens until Run is released.
    Reset = 1'b1;
    Run   = 1'b1;
    tick();
    tick();
    chk("rst acc", 64'(Acc_Out), 64'd0);
    chk("rst busy", 64'(Busy), 64'd0);
    chk("rst done", 64'(Done), 64'd0);
    chk("rst ovf", 64'(Overflow), 64'd0);
    Reset = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    repeat (4) begin
      tick();
      done_cnt += int'(Done);
      busy_cnt += int'(Busy);
    end
    chk("rst run_ignored done", 64'(done_cnt), 64'd0);
    chk("rst run_ignored busy", 64'(busy_cnt), 64'd0);
    Run = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].load, vecs[i].op, vecs[i].exp_acc, vecs[i].exp_ovf, $sformatf("vec%0d", i));
    end

    // Run held for 20 cycles yields exactly one accumulate.
    do_op(1'b1, '0, '0, 1'b0, "hold_load");
    Run      = 1'b1;
    Load_Sel = 1'b0;
    Operand  = W'('h2);
    done_cnt = 0;
    busy_cnt = 0;
    repeat (20) begin
      tick();
      done_cnt += int'(Done);
      busy_cnt += int'(Busy);
    end
    chk("hold done_count", 64'(done_cnt), 64'd1);
    chk("hold busy_count", 64'(busy_cnt), 64'(N));
    chk("hold acc", 64'(Acc_Out), 64'h2);
    Run = 1'b0;
    tick();
    m_acc = (W+1)'('h2);
    do_op(1'b0, W'('h2), (W+1)'('h4), 1'b0, "hold_again");

    // Reset in the middle of an add aborts it.
    do_op(1'b1, ALL1, {1'b0, ALL1}, 1'b0, "abort_load");
    do_op(1'b0, W'('h1), SAT ? SATV : TOPB, 1'b1, "abort_ovf");
    Run      = 1'b1;
    Load_Sel = 1'b0;
    Operand  = W'('h1);
    tick();
    if (N >= 2) tick();
    chk("abort busy_before", 64'(Busy), 64'd1);
    Reset = 1'b1;
    tick();
    chk("abort acc", 64'(Acc_Out), 64'd0);
    chk("abort busy", 64'(Busy), 64'd0);
    chk("abort done", 64'(Done), 64'd0);
    chk("abort ovf", 64'(Overflow), 64'd0);
    Reset = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    repeat (N + 3) begin
      tick();
      done_cnt += int'(Done);
      busy_cnt += int'(Busy);
    end
    chk("abort no_op done", 64'(done_cnt), 64'd0);
    chk("abort no_op busy", 64'(busy_cnt), 64'd0);
    Run = 1'b0;
    tick();
    m_acc = '0;
    m_ovf = 1'b0;
    do_op(1'b0, W'('h3), (W+1)'('h3), 1'b0, "abort_after");

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      r_load = ($urandom_range(0, 3) == 0);
      r_op   = W'($urandom);
      if ($urandom_range(0, 2) == 0) r_op = ALL1 - W'($urandom_range(0, 3));
      if (r_load) begin
        r_exp = {1'b0, r_op};
        r_ovf = 1'b0;
      end else begin
        r_sum = {1'b0, m_acc[W-1:0]} + {1'b0, r_op};
        r_ovf = m_ovf | r_sum[W];
        r_exp = (SAT && r_sum[W]) ? SATV : r_sum;
      end
      do_op(r_load, r_op, r_exp, r_ovf, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
